// File: rtl/hvac_drive_guard.sv
`default_nettype none
// ============================================================================
// Module   : hvac_drive_guard
// Purpose  : Drives the heater and cooler enables from the controller's
//            heat/cool requests. It enforces a minimum on-time, a minimum
//            off-time (lockout) between any two activations, and mutual
//            exclusion of heating and cooling. It also flags conflicting
//            requests and keeps a saturating count of actuator starts.
// Ports    : clk      - system clock, rising edge
//            reset    - asynchronous active-low reset
//            h_req    - heat request
//            c_req    - cool request
//            heat_on  - heater enable (flop output)
//            cool_on  - cooler enable (flop output)
//            lockout  - high while the lockout dwell is running
//            fault    - one-cycle pulse after each sample with both requests high
//            starts   - saturating count of HEAT/COOL entries
// Revision : 1.0 - initial release
// ============================================================================
module hvac_drive_guard #(
    parameter int MIN_ON  = 8,
    parameter int MIN_OFF = 6,
    parameter int CW      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       h_req,
    input  logic       c_req,
    output logic       heat_on,
    output logic       cool_on,
    output logic       lockout,
    output logic       fault,
    output logic [7:0] starts
);

    // One-hot encoding: each output enable is a state bit, so it comes
    // directly from a flop with no combinational path from the inputs.
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_HEAT = 4'b0010,
        ST_COOL = 4'b0100,
        ST_LOCK = 4'b1000
    } state_t;

    localparam logic [CW-1:0] c_ON_LOAD  = CW'(MIN_ON - 1);
    localparam logic [CW-1:0] c_OFF_LOAD = CW'(MIN_OFF - 1);
    localparam logic [CW-1:0] c_ONE      = CW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_fault;
    logic [7:0]    r_starts;

    logic w_heat_ok;
    logic w_cool_ok;
    logic w_conflict;
    logic w_cnt_zero;
    logic w_enter;

    assign w_heat_ok  = h_req & ~c_req;
    assign w_cool_ok  = c_req & ~h_req;
    assign w_conflict = h_req & c_req;
    assign w_cnt_zero = (r_cnt == '0);

    // Only IDLE and LOCKOUT can lead into an active mode, so any edge that
    // lands in HEAT/COOL from another state is a fresh start.
    assign w_enter = ((w_state_nxt == ST_HEAT) && (r_state != ST_HEAT)) ||
                     ((w_state_nxt == ST_COOL) && (r_state != ST_COOL));

    // ------------------------------------------------------------------
    // Next-state and dwell-counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                // A conflict matches neither heat_ok nor cool_ok, so it idles.
                if (w_heat_ok) begin
                    w_state_nxt = ST_HEAT;
                    w_cnt_nxt   = c_ON_LOAD;
                end else if (w_cool_ok) begin
                    w_state_nxt = ST_COOL;
                    w_cnt_nxt   = c_ON_LOAD;
                end
            end
            ST_HEAT: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end else if (!w_heat_ok) begin
                    w_state_nxt = ST_LOCK;
                    w_cnt_nxt   = c_OFF_LOAD;
                end
            end
            ST_COOL: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end else if (!w_cool_ok) begin
                    w_state_nxt = ST_LOCK;
                    w_cnt_nxt   = c_OFF_LOAD;
                end
            end
            ST_LOCK: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end else if (w_heat_ok) begin
                    w_state_nxt = ST_HEAT;
                    w_cnt_nxt   = c_ON_LOAD;
                end else if (w_cool_ok) begin
                    w_state_nxt = ST_COOL;
                    w_cnt_nxt   = c_ON_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                // Illegal encoding: fall back to the safe state with a full
                // off-time so neither actuator can short-cycle.
                w_state_nxt = ST_LOCK;
                w_cnt_nxt   = c_OFF_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counter, fault and start-count registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_LOCK;
            r_cnt    <= c_OFF_LOAD;
            r_fault  <= 1'b0;
            r_starts <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fault <= w_conflict;
            if (w_enter && (r_starts != 8'hFF)) begin
                r_starts <= r_starts + 8'd1;
            end
        end
    end

    assign heat_on = r_state[1];
    assign cool_on = r_state[2];
    assign lockout = r_state[3];
    assign fault   = r_fault;
    assign starts  = r_starts;

endmodule
`default_nettype wire

// File: doc/hvac_drive_guard.md
# hvac_drive_guard

Downstream stage of the temperature controller. Takes its heat/cool request outputs and drives the physical heater and cooler enables. Enforces a minimum on-time, a minimum off-time (lockout) between any two activations, and mutual exclusion of heating and cooling. Flags conflicting requests and keeps a saturating count of actuator starts for diagnostics.

## Interface
- MIN_ON, 8: minimum cycles an enable stays high once asserted (≥1)
- MIN_OFF, 6: minimum cycles both enables stay low between activations (≥1)
- CW, 16: width of the internal dwell counter; must hold max(MIN_ON, MIN_OFF)-1
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- h_req  input  1  heat request (controller `h`)
- c_req  input  1  cool request (controller `c`)
- heat_on  output  1  heater enable, registered
- cool_on  output  1  cooler enable, registered
- lockout  output  1  high while in the LOCKOUT state
- fault  output  1  one-cycle pulse, registered: h_req and c_req sampled high together
- starts  output  8  saturating count of HEAT/COOL entries

## Operation
- States: IDLE, HEAT, COOL, LOCKOUT.
- State is one-hot. heat_on = HEAT bit, cool_on = COOL bit, lockout = LOCKOUT bit. All are flop outputs with no combinational path from the inputs.
- Definitions: heat_ok = h_req & ~c_req; cool_ok = c_req & ~h_req; conflict = h_req & c_req.
- IDLE:
  - heat_ok → HEAT, loading cnt = MIN_ON-1.
  - cool_ok → COOL, loading cnt = MIN_ON-1.
  - Otherwise (including conflict) → stay in IDLE.
- HEAT:
  - If cnt≠0, decrement cnt and stay.
  - If cnt=0 and heat_ok, stay (cnt holds 0).
  - If cnt=0 and not heat_ok, go to LOCKOUT, loading cnt = MIN_OFF-1.
- COOL: symmetric to HEAT, using cool_ok.
- A conflict never extends an active mode: it counts as a drop of the active request. The mode still runs out its minimum on-time.
- LOCKOUT:
  - If cnt≠0, decrement cnt.
  - At cnt=0: heat_ok → HEAT, cool_ok → COOL, else → IDLE. Entries into HEAT or COOL load cnt = MIN_ON-1.
- There is no direct HEAT↔COOL transition. Every mode change passes through LOCKOUT.
- fault: registered copy of conflict, in every state.
- starts: increments on every clock edge that enters HEAT or COOL. Saturates at 255 and never wraps.
- Reset (reset=0), applied asynchronously:
  - state = LOCKOUT, cnt = MIN_OFF-1
  - heat_on = 0, cool_on = 0, lockout = 1
  - fault = 0, starts = 0
- Reset mid-operation drops the enables immediately, with no minimum-on completion. The full MIN_OFF lockout is then enforced after reset release.

## Timing
- Request-to-enable latency from IDLE: 1 cycle. A request sampled at edge N gives the enable high after edge N.
- Any activation keeps its enable high for ≥ MIN_ON cycles. A request that is high for exactly one cycle gives exactly MIN_ON cycles.
- A request dropped (sampled low) at the edge where cnt=0 gives enable low after that edge. Enable high time = max(MIN_ON, request-high cycles as sampled).
- Gap between any two activations: ≥ MIN_OFF cycles. The gap is exactly MIN_OFF if the next request is held through the end of LOCKOUT.
- After reset release, the first enable can rise no earlier than MIN_OFF edges later.
- fault is high for the cycle after each conflicting sample. Consecutive conflicting samples give consecutive fault cycles.
- heat_on and cool_on are never high in the same cycle, and are never both high across any single edge.

## Test plan
All scenarios use MIN_ON=4, MIN_OFF=3.
- Reset lockout:
  - Stimulus: hold h_req=1 from reset release.
  - Required: lockout=1 for 3 cycles, heat_on rises after the 3rd edge, starts=1.
- Short pulse:
  - Stimulus: from IDLE, h_req=1 for 1 cycle.
  - Required: heat_on high exactly 4 cycles, then lockout exactly 3 cycles, then IDLE.
- Long request:
  - Stimulus: h_req=1 for 10 cycles.
  - Required: heat_on high 10 cycles (1-cycle delayed), then 3 lockout cycles.
- Heat to cool switch:
  - Stimulus: h_req=1 for 5 cycles, then c_req=1 held.
  - Required: heat_on falls, cool_on rises exactly 3 cycles later, never overlapping; starts=2.
- Conflict:
  - Stimulus: h_req=c_req=1 for 2 cycles, in IDLE and again in HEAT after MIN_ON.
  - Required: fault pulses 2 cycles each time. IDLE stays IDLE. HEAT exits to LOCKOUT.
- Reset mid-HEAT:
  - Stimulus: assert reset 2 cycles into HEAT.
  - Required: heat_on=0 asynchronously, starts=0, 3-cycle lockout after release.
- Saturation:
  - Stimulus: 300 activations.
  - Required: starts holds at 255.
